adc_sample_fifo_app: RTL and testbench
======================================

// Module: adc_sample_fifo_app
// PURPOSE
//  Bus sub-module on the 16-bit DSP bidirectional bus that buffers the ADC sample stream for DSP reads.
//  It sits downstream of Adc_App and upstream of the bus mux.
//  - Accepts single-cycle sample strobes into a circular FIFO.
//  - The DSP drains the FIFO through a DATA register, monitors it through STATUS and configures it through CTRL.
//  - Raises an interrupt at a programmable fill level.
// PARAMETERS
//  ab_offset    0    added to every register address
//  ADDR_BASE    8'h40  base address of this block (DATA=+0, STATUS=+1, CTRL=+2)
//  DEPTH_LOG2   5    FIFO depth = 2**DEPTH_LOG2 words; legal range 2..7
// PORTS
//  xclk             in   1   bus clock; all logic is on the rising edge
//  reset            in   1   asynchronous, active-low
//  write_qualified  in   1   level, DSP write in progress (already delayed/settled)
//  read_qualified   in   1   level, DSP read in progress
//  ab               in   8   address bus, low byte
//  db_in            in   16  write data
//  db_out_ASF       out  16  read data to the bus mux
//  data_from_ASF_avail out 1 high while this block owns the current read
//  sample_data      in   16  ADC result, xclk domain
//  sample_strobe    in   1   1-cycle push request
//  fifo_irq         out  1   registered interrupt request, active-high
// BEHAVIOUR
//  Clock and reset: reset reset, asynchronous, active-low; clock xclk.
//  Reset values
//   - Pointers and count = 0; CTRL = 16'h0000 (disabled, threshold 0).
//   - Sticky flags cleared; fifo_irq=0; db_out_ASF=0; avail=0.
//  Address match
//   - hit_X = (ab == ab_offset+ADDR_BASE+X).
//   - data_from_ASF_avail = read_qualified & (hit_0|hit_1|hit_2), combinational.
//   - db_out_ASF is combinational from the selected register; it is 0 when there is no hit.
//  DATA read
//   - Returns the head word (mem[rd_ptr]), or 16'h0000 when empty.
//   - Pop fires exactly once per read, one cycle after read_qualified falls.
//   - The address hit is latched while read_qualified is high, so ab changes after the read cannot retarget the pop.
//   - A read while empty sets UNDERFLOW and does not pop.
//  STATUS read (read-only)
//   - [15] OVERFLOW sticky, [14] UNDERFLOW sticky, [13] ENABLE, [12] fifo_irq, [11:8] 0.
//   - [7:0] count, zero-extended; count width is DEPTH_LOG2+1.
//  CTRL write
//   - Acts once, on the rising edge of write_qualified with hit_2 (edge-detect register).
//   - [0] ENABLE; [1] FLUSH, self-clearing; [2] CLR_FLAGS, self-clearing; [13:8] THRESH.
//   - CTRL read returns {2'b0, THRESH, 7'b0, ENABLE}.
//  Push
//   - sample_strobe & ENABLE: write mem[wr_ptr] and increment wr_ptr.
//   - Count updates on the next edge (N strobe -> N+1 visible).
//   - Strobe while disabled is ignored; FIFO contents are retained.
//  Full
//   - Push dropped and OVERFLOW set, unless a pop fires in the same cycle.
//   - With a same-cycle pop, the push is accepted and count is unchanged.
//  Empty
//   - A pop request in the same cycle as a push is rejected: UNDERFLOW set, count becomes 1.
//  Wrap-around
//   - Pointers are DEPTH_LOG2 bits and wrap naturally; full = count == 2**DEPTH_LOG2.
//  Simultaneous push & pop when 0 < count < full: both happen, count unchanged.
//  FLUSH
//   - Zeroes both pointers and count.
//   - Wins over a same-cycle push and pop; the sample is discarded and no flag is set.
//  CLR_FLAGS
//   - Clears both sticky flags.
//   - A flag event in the same cycle wins, so the flag stays set.
//  fifo_irq
//   - Registered value of ENABLE & ((THRESH != 0 & count >= THRESH) | OVERFLOW).
//   - Falls one cycle after the condition clears.
//  DSP write to DATA or STATUS: ignored.
//  Reset asserted mid-read or mid-push: immediate return to reset values; no partial pop or push.
// STRUCTURE
//  Package asf_pkg
//   - Register offsets (ASF_DATA=0, ASF_STATUS=1, ASF_CTRL=2).
//   - STATUS/CTRL bit positions.
//   - THRESH field width 6.
//  Sub-module sample_fifo_core
//   - Parameterised circular buffer: push, pop, flush; outputs head, count, full, empty.
//   - Distributed RAM with asynchronous read.
//  Top level: address decode, read-edge pop logic, CTRL register, flags and irq.
// TESTING
//  1. Reset, then read STATUS -> 16'h0000. Read DATA -> 16'h0000, UNDERFLOW set (STATUS=16'h4000).
//  2. CTRL=16'h0001; strobe 1,2,3 -> STATUS=16'h2003. Three DATA reads -> 1,2,3, each popping exactly once with read_qualified held 4 cycles.
//  3. DEPTH_LOG2=5: 33 strobes -> count=32, OVERFLOW set, 33rd sample lost. Drain 32 -> wrap-correct order.
//  4. Full FIFO, strobe in the pop cycle -> accepted; count stays 32; OVERFLOW unchanged.
//  5. THRESH=4 (CTRL=16'h0401): 4th strobe -> fifo_irq high on the next cycle. One pop -> irq low one cycle after.
//  6. FLUSH with a concurrent strobe -> count=0, flags unchanged. Assert reset mid-read -> db_out/avail=0; no pop after release.

Source files
------------

// File: rtl/asf_pkg.sv
// Shared register map, bit positions and field widths for the ADC sample FIFO bus block.
package asf_pkg;

  localparam int ASF_DATA   = 0;
  localparam int ASF_STATUS = 1;
  localparam int ASF_CTRL   = 2;

  localparam int STAT_OVF = 15;
  localparam int STAT_UNF = 14;
  localparam int STAT_EN  = 13;
  localparam int STAT_IRQ = 12;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR     = 2;
  localparam int CTRL_THR_LSB = 8;
  localparam int THRESH_W     = 6;

endpackage

// File: rtl/sample_fifo_core.sv
// Circular sample buffer with asynchronous-read distributed RAM; push/pop/flush arrive pre-qualified.
module sample_fifo_core #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  xclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [15:0]           wr_data,
  output logic [15:0]           head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // NOTE: the storage array has no reset; validity is tracked by count, so
  // resetting it would only cost logic and block distributed-RAM mapping.
  always_ff @(posedge xclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);
  assign head  = empty ? 16'h0000 : mem[rd_ptr];

endmodule

// File: rtl/adc_sample_fifo_app.sv
// DSP bus front end for the ADC sample FIFO: address decode, DATA/STATUS/CTRL, read-edge pop, flags, irq.
module adc_sample_fifo_app
  import asf_pkg::*;
#(
  parameter int         ab_offset  = 0,
  parameter logic [7:0] ADDR_BASE  = 8'h40,
  parameter int         DEPTH_LOG2 = 5
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        write_qualified,
  input  logic        read_qualified,
  input  logic [7:0]  ab,
  input  logic [15:0] db_in,
  output logic [15:0] db_out_ASF,
  output logic        data_from_ASF_avail,
  input  logic [15:0] sample_data,
  input  logic        sample_strobe,
  output logic        fifo_irq
);

  localparam logic [7:0] A_DATA   = 8'(ab_offset + int'(ADDR_BASE) + ASF_DATA);
  localparam logic [7:0] A_STATUS = 8'(ab_offset + int'(ADDR_BASE) + ASF_STATUS);
  localparam logic [7:0] A_CTRL   = 8'(ab_offset + int'(ADDR_BASE) + ASF_CTRL);

  logic hit_data, hit_status, hit_ctrl;
  logic rd_q, wr_q, rd_hit;
  logic enable;
  logic [THRESH_W-1:0] thresh;
  logic ovf, unf;
  logic ctrl_wr, flush, clr_flags;
  logic push_req, pop_req, do_push, do_pop;
  logic [15:0] head;
  logic [DEPTH_LOG2:0] count;
  logic [7:0] count8;
  logic full, empty;
  logic [15:0] status_word, ctrl_word;
  logic unused_db_bits;

  assign hit_data   = (ab == A_DATA);
  assign hit_status = (ab == A_STATUS);
  assign hit_ctrl   = (ab == A_CTRL);

  assign data_from_ASF_avail = reset & read_qualified & (hit_data | hit_status | hit_ctrl);

  // Pop is tied to the falling edge of the read, using the hit captured while it was high.
  assign pop_req  = rd_q & ~read_qualified & rd_hit;
  assign push_req = sample_strobe & enable;

  assign ctrl_wr   = write_qualified & ~wr_q & hit_ctrl;
  assign flush     = ctrl_wr & db_in[CTRL_FLUSH];
  assign clr_flags = ctrl_wr & db_in[CTRL_CLR];

  assign do_pop  = pop_req & ~empty & ~flush;
  assign do_push = push_req & ~flush & (~full | do_pop);

  assign count8 = 8'(count);
  assign unused_db_bits = ^{db_in[15:14], db_in[7:3]};

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_hit   <= 1'b0;
      enable   <= 1'b0;
      thresh   <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      fifo_irq <= 1'b0;
    end else begin
      rd_q <= read_qualified;
      wr_q <= write_qualified;
      if (read_qualified) rd_hit <= (rd_q & rd_hit) | hit_data;
      else                rd_hit <= 1'b0;

      if (ctrl_wr) begin
        enable <= db_in[CTRL_EN];
        thresh <= db_in[CTRL_THR_LSB +: THRESH_W];
      end

      // A same-cycle flag event outranks CLR_FLAGS.
      if (push_req & full & ~do_pop & ~flush) ovf <= 1'b1;
      else if (clr_flags)                     ovf <= 1'b0;
      if (pop_req & empty & ~flush)           unf <= 1'b1;
      else if (clr_flags)                     unf <= 1'b0;

      fifo_irq <= enable & (((thresh != '0) & (count8 >= {2'b00, thresh})) | ovf);
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    status_word = '0;
    status_word[STAT_OVF] = ovf;
    status_word[STAT_UNF] = unf;
    status_word[STAT_EN]  = enable;
    status_word[STAT_IRQ] = fifo_irq;
    status_word[7:0]      = count8;
    ctrl_word = '0;
    ctrl_word[CTRL_EN] = enable;
    ctrl_word[CTRL_THR_LSB +: THRESH_W] = thresh;
    db_out_ASF = '0;
    if (reset) begin
      if (hit_data)        db_out_ASF = head;
      else if (hit_status) db_out_ASF = status_word;
      else if (hit_ctrl)   db_out_ASF = ctrl_word;
    end
  end

  sample_fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_core (
    .xclk    (xclk),
    .reset   (reset),
    .push    (do_push),
    .pop     (do_pop),
    .flush   (flush),
    .wr_data (sample_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_adc_sample_fifo_app.sv
// Directed self-checking bench for adc_sample_fifo_app with default parameters (base 8'h40, depth 32).
module tb_adc_sample_fifo_app;

  localparam logic [7:0] A_DATA   = 8'h40;
  localparam logic [7:0] A_STATUS = 8'h41;
  localparam logic [7:0] A_CTRL   = 8'h42;

  logic        xclk = 1'b0;
  logic        reset;
  logic        write_qualified;
  logic        read_qualified;
  logic [7:0]  ab;
  logic [15:0] db_in;
  logic [15:0] db_out_ASF;
  logic        data_from_ASF_avail;
  logic [15:0] sample_data;
  logic        sample_strobe;
  logic        fifo_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 xclk = ~xclk;

  adc_sample_fifo_app dut (
    .xclk                (xclk),
    .reset               (reset),
    .write_qualified     (write_qualified),
    .read_qualified      (read_qualified),
    .ab                  (ab),
    .db_in               (db_in),
    .db_out_ASF          (db_out_ASF),
    .data_from_ASF_avail (data_from_ASF_avail),
    .sample_data         (sample_data),
    .sample_strobe       (sample_strobe),
    .fifo_irq            (fifo_irq)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d);
    sample_data   = d;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] d);
    ab = addr;
    db_in = d;
    write_qualified = 1'b1;
    tick();
    tick();
    write_qualified = 1'b0;
    tick();
  endtask

  // Holds the read for 'hold' edges, samples, then drops the read (and moves ab away);
  // optionally strobes a sample into the pop cycle.
  task automatic bus_read(input logic [7:0] addr, input int hold, input logic push_at_pop,
                          input logic [15:0] pdata, output logic [15:0] d, output logic av);
    ab = addr;
    read_qualified = 1'b1;
    repeat (hold) tick();
    d  = db_out_ASF;
    av = data_from_ASF_avail;
    read_qualified = 1'b0;
    ab = 8'h00;
    if (push_at_pop) begin
      sample_data   = pdata;
      sample_strobe = 1'b1;
    end
    tick();
    sample_strobe = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic        av;

    reset = 1'b0;
    write_qualified = 1'b0;
    read_qualified = 1'b0;
    ab = 8'h00;
    db_in = 16'h0000;
    sample_data = 16'h0000;
    sample_strobe = 1'b0;
    repeat (3) @(posedge xclk);
    #1 reset = 1'b1;
    tick();

    // Reset state and empty read
    check("rst_irq", {15'b0, fifo_irq}, 16'h0000);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("rst_status", d, 16'h0000);
    check("status_avail", {15'b0, av}, 16'h0001);
    bus_read(A_DATA, 1, 1'b0, 16'h0, d, av);
    check("empty_data", d, 16'h0000);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("underflow_status", d, 16'h4000);

    ab = 8'h10;
    read_qualified = 1'b1;
    #1;
    check("nohit_dbout", db_out_ASF, 16'h0000);
    check("nohit_avail", {15'b0, data_from_ASF_avail}, 16'h0000);
    read_qualified = 1'b0;
    tick();
    tick();

    bus_write(A_CTRL, 16'h0004);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("clr_flags_status", d, 16'h0000);

    // Basic push and drain
    bus_write(A_CTRL, 16'h0001);
    strobe(16'd1);
    strobe(16'd2);
    strobe(16'd3);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("three_status", d, 16'h2003);
    for (int i = 1; i <= 3; i++) begin
      bus_read(A_DATA, 4, 1'b0, 16'h0, d, av);
      check($sformatf("pop_%0d_data", i), d, 16'(i));
      bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
      check($sformatf("pop_%0d_status", i), d, 16'(16'h2003 - i));
    end

    // Fill past full (pointers start at 3, so this wraps)
    for (int i = 0; i <= 32; i++) strobe(16'(16'h0100 + i));
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("full_ovf_status", d, 16'hB020);

    bus_write(A_CTRL, 16'h0005);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("full_clr_status", d, 16'h2020);

    // Pop from full with a strobe in the pop cycle
    bus_read(A_DATA, 1, 1'b1, 16'h0200, d, av);
    check("full_pop_data", d, 16'h0100);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("full_pushpop_status", d, 16'h2020);

    for (int i = 1; i <= 31; i++) begin
      bus_read(A_DATA, 1, 1'b0, 16'h0, d, av);
      check($sformatf("drain_%0d", i), d, 16'(16'h0100 + i));
    end
    bus_read(A_DATA, 1, 1'b0, 16'h0, d, av);
    check("drain_last", d, 16'h0200);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("drained_status", d, 16'h2000);

    // Threshold interrupt
    bus_write(A_CTRL, 16'h0401);
    bus_read(A_CTRL, 1, 1'b0, 16'h0, d, av);
    check("ctrl_readback", d, 16'h0401);
    strobe(16'h0011);
    strobe(16'h0022);
    strobe(16'h0033);
    tick();
    check("irq_below_thresh", {15'b0, fifo_irq}, 16'h0000);
    strobe(16'h0044);
    tick();
    check("irq_at_thresh", {15'b0, fifo_irq}, 16'h0001);
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("irq_status", d, 16'h3004);
    bus_read(A_DATA, 1, 1'b0, 16'h0, d, av);
    check("irq_pop_data", d, 16'h0011);
    check("irq_after_pop", {15'b0, fifo_irq}, 16'h0001);
    tick();
    check("irq_falls", {15'b0, fifo_irq}, 16'h0000);

    // FLUSH with a concurrent strobe
    ab = A_CTRL;
    db_in = 16'h0003;
    write_qualified = 1'b1;
    sample_data = 16'h0055;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    write_qualified = 1'b0;
    tick();
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("flush_status", d, 16'h2000);

    // Reset in the middle of a DATA read
    strobe(16'h0066);
    strobe(16'h0077);
    ab = A_DATA;
    read_qualified = 1'b1;
    tick();
    tick();
    check("midread_head", db_out_ASF, 16'h0066);
    reset = 1'b0;
    #1;
    check("rst_midread_dbout", db_out_ASF, 16'h0000);
    check("rst_midread_avail", {15'b0, data_from_ASF_avail}, 16'h0000);
    read_qualified = 1'b0;
    ab = 8'h00;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    bus_read(A_STATUS, 1, 1'b0, 16'h0, d, av);
    check("post_reset_status", d, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
